apb_logic_unit_mc: RTL and testbench

Multi-channel, parameterised APB logic unit. It is the successor to the single-channel operand/control/result APB slave. It provides NUM_CH independent channels, each with OPA, OPB, CTRL and a read-only RESULT register. A CTRL write starts a multi-cycle compute, and the slave inserts APB wait states on accesses that would race a busy channel. It sits on the peripheral APB bus behind the system bridge, as a test/utility peripheral.

---
 rtl/apb_logic_unit_mc.sv | 144 ++++++++++++++
 tb/tb_apb_logic_unit_mc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_logic_unit_mc.sv
// Multi-channel APB logic unit: per-channel OPA/OPB/CTRL/RESULT with a
// multi-cycle bitwise compute and wait-state insertion on busy channels.
module apb_logic_unit_mc #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int NUM_CH  = 4,
    parameter int LATENCY = 2
) (
    input  logic                pclk,
    input  logic                reset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [NUM_CH-1:0]   busy
);
    localparam int NB    = DATA_W / 8;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [ADDR_W-4:0] NUM_CH_L = (ADDR_W-3)'(NUM_CH);
    localparam logic [CNT_W-1:0]  LAT_L    = CNT_W'(LATENCY);

    function automatic logic [DATA_W-1:0] alu_op(input logic [2:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (op)
            3'd0:    return a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            3'd7:    return ~a;
            default: return a;
        endcase
    endfunction

    logic [DATA_W-1:0] opa_q    [NUM_CH];
    logic [DATA_W-1:0] opa_d    [NUM_CH];
    logic [DATA_W-1:0] opb_q    [NUM_CH];
    logic [DATA_W-1:0] opb_d    [NUM_CH];
    logic [DATA_W-1:0] result_q [NUM_CH];
    logic [DATA_W-1:0] result_d [NUM_CH];
    logic [2:0]        ctrl_q   [NUM_CH];
    logic [2:0]        ctrl_d   [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];

    logic [ADDR_W-5:0] ch_full;
    logic [CH_W-1:0]   ch_sel;
    logic [1:0]        off;
    logic              access;
    logic              err;
    logic              stall;
    logic              fire;

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_busy
        assign busy[g] = (cnt_q[g] != CNT_W'(0));
    end

    // Address decode, error/stall classification and handshake outputs
    always_comb begin
        ch_full = paddr[ADDR_W-1:4];
        ch_sel  = ch_full[CH_W-1:0];
        off     = paddr[3:2];
        access  = psel & penable & ~reset;
        err     = ({1'b0, ch_full} >= NUM_CH_L) | (paddr[1:0] != 2'b00) |
                  (pwrite & (off == 2'd3));
        // Only writes and RESULT reads race an in-flight compute
        stall   = ~err & busy[ch_sel] & (pwrite | (off == 2'd3));
        pready  = access & (err | ~stall);
        pslverr = access & err;
        fire    = pready & pwrite & ~err;
    end

    // Read data mux, gated to completed error-free reads
    always_comb begin
        prdata = {DATA_W{1'b0}};
        if (pready & ~pwrite & ~err) begin
            case (off)
                2'd0:    prdata = opa_q[ch_sel];
                2'd1:    prdata = opb_q[ch_sel];
                2'd2:    prdata = {{(DATA_W-3){1'b0}}, ctrl_q[ch_sel]};
                2'd3:    prdata = result_q[ch_sel];
                default: prdata = {DATA_W{1'b0}};
            endcase
        end else begin
            prdata = {DATA_W{1'b0}};
        end
    end

    // Per-channel register writes, compute countdown and result capture
    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < NB; b++) begin
                opa_d[c][8*b +: 8] = (fire && ch_sel == CH_W'(c) && off == 2'd0 && pstrb[b]) ?
                                     pwdata[8*b +: 8] : opa_q[c][8*b +: 8];
                opb_d[c][8*b +: 8] = (fire && ch_sel == CH_W'(c) && off == 2'd1 && pstrb[b]) ?
                                     pwdata[8*b +: 8] : opb_q[c][8*b +: 8];
            end
            if (fire && ch_sel == CH_W'(c) && off == 2'd2) begin
                ctrl_d[c] = pwdata[2:0];
                cnt_d[c]  = LAT_L;
            end else if (cnt_q[c] != CNT_W'(0)) begin
                cnt_d[c]  = cnt_q[c] - CNT_W'(1);
            end else begin
                cnt_d[c]  = cnt_q[c];
            end
            result_d[c] = (cnt_q[c] == CNT_W'(1)) ?
                          alu_op(ctrl_q[c], opa_q[c], opb_q[c]) : result_q[c];
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                opa_q[c]    <= {DATA_W{1'b0}};
                opb_q[c]    <= {DATA_W{1'b0}};
                result_q[c] <= {DATA_W{1'b0}};
                ctrl_q[c]   <= 3'd0;
                cnt_q[c]    <= CNT_W'(0);
            end
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_apb_logic_unit_mc.sv
// Scoreboard bench for apb_logic_unit_mc: a transaction-level model predicts
// read data, error and wait-state count; a monitor checks each completion.
module tb_apb_logic_unit_mc;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int NC  = 4;
    localparam int LAT = 2;

    logic          pclk = 1'b0;
    logic          reset;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;
    logic [NC-1:0] busy;

    apb_logic_unit_mc #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .LATENCY(LAT)) dut (
        .pclk(pclk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .busy(busy)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            waits;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: register contents plus the cycle window each channel is busy
    logic [DW-1:0] m_opa [NC];
    logic [DW-1:0] m_opb [NC];
    logic [DW-1:0] m_res [NC];
    logic [2:0]    m_op  [NC];
    int            m_start [NC];
    int            m_done  [NC];
    int            m_pdone [NC];

    function automatic logic [DW-1:0] ref_op(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            3'd0: return a;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return ~a;
        endcase
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            m_opa[c] = '0; m_opb[c] = '0; m_res[c] = '0; m_op[c] = 3'd0;
            m_start[c] = 0; m_done[c] = 0; m_pdone[c] = 0;
        end
    endtask

    // One APB transfer; entered and left #1 after a rising edge
    task automatic apb(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [3:0] st);
        exp_t e, drop;
        int a, c, off, n;
        logic ok;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(posedge pclk); #1;
        penable = 1'b1;
        a   = cyc;
        c   = int'(addr) / 16;
        off = (int'(addr) % 16) / 4;
        e.err   = (int'(addr) >= NC * 16) || (addr[1:0] != 2'b00) || (wr && off == 3);
        e.data  = '0;
        e.waits = 0;
        if (!e.err) begin
            if ((wr || off == 3) && m_done[c] > a) e.waits = m_done[c] - a;
            n = a + e.waits + 1;
            if (wr) begin
                case (off)
                    0: for (int b = 0; b < 4; b++) if (st[b]) m_opa[c][8*b +: 8] = wd[8*b +: 8];
                    1: for (int b = 0; b < 4; b++) if (st[b]) m_opb[c][8*b +: 8] = wd[8*b +: 8];
                    default: begin
                        m_op[c]    = wd[2:0];
                        m_res[c]   = ref_op(wd[2:0], m_opa[c], m_opb[c]);
                        m_pdone[c] = m_done[c];
                        m_start[c] = n;
                        m_done[c]  = n + LAT;
                    end
                endcase
            end else begin
                case (off)
                    0: e.data = m_opa[c];
                    1: e.data = m_opb[c];
                    2: e.data = {29'd0, m_op[c]};
                    default: e.data = m_res[c];
                endcase
            end
        end
        q.push_back(e);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge pclk);
            if (pready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            $display("FAIL timeout addr=%h: got no pready in 64 cycles, required pready=1", addr);
            vectors++; miscompares++;
            drop = q.pop_back();
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Monitor: per-cycle busy check and scoreboard pop on each completed transfer
    initial begin
        exp_t e;
        int waits_seen;
        logic [NC-1:0] exp_busy;
        waits_seen = 0;
        forever begin
            @(negedge pclk);
            if (reset) begin
                waits_seen = 0;
            end else begin
                exp_busy = '0;
                for (int c = 0; c < NC; c++)
                    if ((cyc >= m_start[c] && cyc < m_done[c]) || cyc < m_pdone[c]) exp_busy[c] = 1'b1;
                vectors++;
                if (busy !== exp_busy) begin
                    miscompares++;
                    $display("FAIL busy cyc=%0d: got %b, required %b", cyc, busy, exp_busy);
                end
                if (psel && penable) begin
                    if (!pready) begin
                        waits_seen++;
                    end else begin
                        vectors++;
                        if (q.size() == 0) begin
                            miscompares++;
                            $display("FAIL xfer addr=%h: unexpected completion, no transfer pending", paddr);
                        end else begin
                            e = q.pop_front();
                            if (pslverr !== e.err || prdata !== e.data || waits_seen != e.waits) begin
                                miscompares++;
                                $display("FAIL xfer addr=%h wr=%b: got err=%b data=%h waits=%0d, required err=%b data=%h waits=%0d",
                                         paddr, pwrite, pslverr, prdata, waits_seen, e.err, e.data, e.waits);
                            end
                        end
                        waits_seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        model_clear();
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge pclk);
        #1 reset = 1'b0;

        // Reset state of every register
        for (int a = 0; a < NC * 16; a += 4) apb(1'b0, AW'(a), '0, 4'h0);

        // Operand writes and readback
        apb(1'b1, 12'h000, 32'hAAAAAAAA, 4'hF);
        apb(1'b1, 12'h004, 32'h0F0F0F0F, 4'hF);
        apb(1'b0, 12'h000, '0, 4'h0);
        apb(1'b0, 12'h004, '0, 4'h0);

        // Ops 1..4, each followed immediately by a RESULT read
        for (int op = 1; op <= 4; op++) begin
            apb(1'b1, 12'h008, DW'(op), 4'h0);
            apb(1'b0, 12'h00C, '0, 4'h0);
        end
        apb(1'b0, 12'h008, '0, 4'h0);

        // Error paths
        apb(1'b1, 12'h00C, 32'hDEADBEEF, 4'hF);
        apb(1'b0, 12'h040, '0, 4'h0);
        apb(1'b1, 12'h002, 32'h11111111, 4'hF);
        apb(1'b0, 12'h00C, '0, 4'h0);

        // Byte strobes
        apb(1'b1, 12'h000, 32'h00000000, 4'hF);
        apb(1'b1, 12'h000, 32'h12345678, 4'b0101);
        apb(1'b0, 12'h000, '0, 4'h0);

        // Overlapping computes on channels 0 and 1
        apb(1'b1, 12'h010, 32'hFFFF0000, 4'hF);
        apb(1'b1, 12'h008, 32'd1, 4'hF);
        apb(1'b1, 12'h018, 32'd7, 4'hF);
        apb(1'b0, 12'h01C, '0, 4'h0);
        apb(1'b0, 12'h00C, '0, 4'h0);

        // Back-to-back: OPB write right after CTRL stalls; RESULT uses old OPB
        apb(1'b1, 12'h020, 32'hC3C3C3C3, 4'hF);
        apb(1'b1, 12'h024, 32'hFF00FF00, 4'hF);
        apb(1'b1, 12'h028, 32'd3, 4'hF);
        apb(1'b1, 12'h024, 32'h0000FFFF, 4'hF);
        apb(1'b0, 12'h02C, '0, 4'h0);
        apb(1'b1, 12'h028, 32'd3, 4'hF);
        apb(1'b1, 12'h028, 32'd6, 4'hF);
        apb(1'b0, 12'h02C, '0, 4'h0);

        // Randomized traffic, including out-of-range and misaligned addresses
        for (int i = 0; i < 300; i++) begin
            int ch, off;
            logic [AW-1:0] a;
            ch  = $urandom_range(0, NC);
            off = $urandom_range(0, 3);
            a   = AW'(ch * 16 + off * 4);
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) a = AW'($urandom_range(64, 4095));
            apb(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset while channel 0 is computing
        apb(1'b1, 12'h000, 32'h5A5A5A5A, 4'hF);
        apb(1'b1, 12'h008, 32'd5, 4'hF);
        reset = 1'b1;
        model_clear();
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h00C;
        @(negedge pclk);
        vectors++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || busy !== '0 || prdata !== '0) begin
            miscompares++;
            $display("FAIL in_reset: got pready=%b pslverr=%b busy=%b prdata=%h, required all 0",
                     pready, pslverr, busy, prdata);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        reset = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        for (int a = 0; a < NC * 16; a += 4) apb(1'b0, AW'(a), '0, 4'h0);

        repeat (3) @(posedge pclk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending transfers, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
